// File: rtl/ru_param.sv
// Parametrised register unit: NREGS x XLEN registers with x0 hardwired to zero,
// two combinational read ports, a debug read port, one write port and a dirty mask.
module ru_param #(
  parameter int          XLEN    = 32,
  parameter int          NREGS   = 32,
  parameter int          SP_IDX  = 2,
  parameter logic [31:0] SP_INIT = 32'h0000_0400,
  parameter int          BYPASS  = 1,
  localparam int         AW      = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ruWr,
  input  logic [AW-1:0]    rd,
  input  logic [XLEN-1:0]  DataWr,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  output logic [XLEN-1:0]  ruRs1,
  output logic [XLEN-1:0]  ruRs2,
  input  logic [AW-1:0]    dbgAddr,
  output logic [XLEN-1:0]  dbgData,
  input  logic             clrDirty,
  output logic [NREGS-1:0] dirty
);

  localparam logic [XLEN-1:0] SP_INIT_X = XLEN'(SP_INIT);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] dirty_q, dirty_d;
  logic             wr_acc;

  // A write is accepted only outside reset and never to x0.
  assign wr_acc = ruWr && !rst && (rd != '0);

  always_comb begin
    regs_d  = regs_q;
    dirty_d = clrDirty ? '0 : dirty_q;
    if (wr_acc) begin
      regs_d[rd]  = DataWr;
      dirty_d[rd] = 1'b1;
    end
    regs_d[0]  = '0;
    dirty_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_INIT_X : '0;
      end
      dirty_q <= '0;
    end else begin
      regs_q  <= regs_d;
      dirty_q <= dirty_d;
    end
  end

  logic [XLEN-1:0] rs1_stored, rs2_stored;

  always_comb begin
    rs1_stored = (rs1 == '0) ? '0 : regs_q[rs1];
    rs2_stored = (rs2 == '0) ? '0 : regs_q[rs2];
    ruRs1      = rs1_stored;
    ruRs2      = rs2_stored;
    if (BYPASS != 0 && wr_acc && rd == rs1) ruRs1 = DataWr;
    if (BYPASS != 0 && wr_acc && rd == rs2) ruRs2 = DataWr;
  end

  // Debug port deliberately ignores any write pending this cycle.
  assign dbgData = (dbgAddr == '0) ? '0 : regs_q[dbgAddr];
  assign dirty   = dirty_q;

endmodule
